// File: rtl/syn_re_counter10_pkg.sv
// Shared constants and types for the decade counter.
package syn_re_counter10_pkg;
   localparam int COUNT_W   = 4;
   localparam int COUNT_MAX = 9;
   localparam int COUNT_RST = 0;

   typedef logic [COUNT_W-1:0] count_t;
endpackage

// File: rtl/syn_re_counter10.sv
// Modulo-MODULUS up-counter, async active-low reset, no enable or load.
// Optional terminal-count flag when SYN_RE_COUNTER10_CARRY_EN is defined.
module syn_re_counter10
   import syn_re_counter10_pkg::*;
#(
   parameter int MODULUS = COUNT_MAX + 1,
   parameter int WIDTH   = COUNT_W
) (
   input  logic             clk,
   input  logic             reset,
`ifdef SYN_RE_COUNTER10_CARRY_EN
   output logic             carry,
`endif
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RSTV = WIDTH'(COUNT_RST);

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_nxt;

   // >= rather than == so any illegal state recovers to zero in one edge
   always_comb begin
      cnt_nxt = cnt + WIDTH'(1);
      if (cnt >= TERM) cnt_nxt = RSTV;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt <= RSTV;
      else        cnt <= cnt_nxt;
   end

   assign q = cnt;

`ifdef SYN_RE_COUNTER10_CARRY_EN
   assign carry = (cnt == TERM);
`endif

endmodule

// File: tb/tb_syn_re_counter10.sv
// Bench for syn_re_counter10: table-driven vectors through a scoreboard queue,
// plus hand sequences for async reset, wrap, carry and illegal-state recovery.
module tb_syn_re_counter10;
   import syn_re_counter10_pkg::*;

   logic   clk;
   logic   reset;
   count_t q;
`ifdef SYN_RE_COUNTER10_CARRY_EN
   logic   carry;
`endif

   syn_re_counter10 dut (
      .clk   (clk),
      .reset (reset),
`ifdef SYN_RE_COUNTER10_CARRY_EN
      .carry (carry),
`endif
      .q     (q)
   );

   typedef struct {
      logic   rst_n;
      logic   do_edge;
      count_t exp_q;
   } vec_t;

   vec_t   vecs[$];
   count_t sb[$];
   int     n_tests = 0;
   int     n_fail  = 0;

   task automatic tick();
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // pop the oldest expectation and compare against the live output
   task automatic sb_check(input string name);
      count_t e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         chk(name, 32'(q), 32'(e));
      end
   endtask

   task automatic step_exp(input string name, input count_t e);
      sb.push_back(e);
      tick();
      sb_check(name);
   endtask

   initial begin
      clk   = 1'b0;
      reset = 1'b0;

      // reset held while clocking, release, then the 20-edge full cycle
      vecs.push_back('{1'b0, 1'b0, 4'd0});
      vecs.push_back('{1'b0, 1'b1, 4'd0});
      vecs.push_back('{1'b0, 1'b1, 4'd0});
      vecs.push_back('{1'b1, 1'b0, 4'd0});
      for (int i = 1; i <= 20; i++)
         vecs.push_back('{1'b1, 1'b1, count_t'(i % 10)});

      #3;
      foreach (vecs[i]) begin
         reset = vecs[i].rst_n;
         #1;
         sb.push_back(vecs[i].exp_q);
         if (vecs[i].do_edge) tick();
         else #2;
         sb_check($sformatf("vec%0d", i));
      end

      // async reset mid-count at q=2
      step_exp("mid_1", 4'd1);
      step_exp("mid_2", 4'd2);
      reset = 1'b0;
      #1;
      chk("async_clr", 32'(q), 32'd0);
      step_exp("edge_in_rst", 4'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("post_release", 32'(q), 32'd0);
      step_exp("rel_1", 4'd1);
      step_exp("rel_2", 4'd2);

      // reset pulse inside one low phase
      reset = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      chk("pulse_clr", 32'(q), 32'd0);
      step_exp("pulse_1", 4'd1);

      // walk to 9 then wrap, checking carry each cycle when present
      for (int i = 2; i <= 9; i++) step_exp("to_nine", count_t'(i));
`ifdef SYN_RE_COUNTER10_CARRY_EN
      chk("carry_at9", 32'(carry), 32'd1);
`endif
      step_exp("wrap_0", 4'd0);
      step_exp("wrap_1", 4'd1);
`ifdef SYN_RE_COUNTER10_CARRY_EN
      begin
         int hi;
         hi = 0;
         for (int i = 2; i <= 11; i++) begin
            step_exp("carry_run", count_t'(i % 10));
            chk("carry_vs_q", 32'(carry), 32'(q == 4'd9));
            if (carry) hi++;
         end
         chk("carry_count", 32'(hi), 32'd1);
      end
`endif

      // illegal state: forced from 3 to 12, one edge must give 0 (not 4)
      step_exp("pre_ill_2", 4'd2);
      step_exp("pre_ill_3", 4'd3);
      force dut.cnt = 4'd12;
      #1;
      release dut.cnt;
      #1;
      step_exp("illegal_recover", 4'd0);
      step_exp("illegal_next", 4'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
